// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter: bus widths, rw encoding, FSM states.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // One requester's transaction fields, bundled for the grant mux.
  typedef struct packed {
    logic                  rw;
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
  } i2c_req_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the requester that did not win last time goes.
// No latency, no state: the caller owns the 'last' register.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic valid
);

  assign valid = req0 | req1;

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between two requesters using fixed-length enable windows plus a release gap.
// Grant to done is TXN_CYCLES edges; a pending req simply waits while busy, nothing is dropped.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int TXN_CYCLES = 64,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  rw0,
  input  logic [I2C_ADDR_W-1:0] addr0,
  input  logic [I2C_DATA_W-1:0] wdata0,
  output logic                  done0,
  output logic [I2C_DATA_W-1:0] rdata0,
  input  logic                  req1,
  input  logic                  rw1,
  input  logic [I2C_ADDR_W-1:0] addr1,
  input  logic [I2C_DATA_W-1:0] wdata1,
  output logic                  done1,
  output logic [I2C_DATA_W-1:0] rdata1,
  output logic                  m_enable,
  output logic                  m_rw,
  output logic [I2C_ADDR_W-1:0] m_addr,
  output logic [I2C_DATA_W-1:0] m_data_in,
  input  logic [I2C_DATA_W-1:0] m_data_out,
  output logic                  busy,
  output logic                  grant_id
);

  localparam int CNT_W = $clog2(max2(TXN_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] TXN_LAST = CNT_W'(TXN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  last, last_nxt;
  logic                  en_nxt, rw_nxt, done0_nxt, done1_nxt, busy_nxt, gid_nxt;
  logic [I2C_ADDR_W-1:0] addr_nxt;
  logic [I2C_DATA_W-1:0] din_nxt, rdata0_nxt, rdata1_nxt;
  logic                  win, win_vld;
  i2c_req_t              sel;

  rr_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (win),
    .valid  (win_vld)
  );

  assign sel = win ? '{rw: rw1, addr: addr1, data: wdata1}
                   : '{rw: rw0, addr: addr0, data: wdata0};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_nxt   = last;
    en_nxt     = m_enable;
    rw_nxt     = m_rw;
    addr_nxt   = m_addr;
    din_nxt    = m_data_in;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    rdata0_nxt = rdata0;
    rdata1_nxt = rdata1;
    busy_nxt   = busy;
    gid_nxt    = grant_id;
    case (state)
      IDLE: begin
        if (win_vld) begin
          rw_nxt    = sel.rw;
          addr_nxt  = sel.addr;
          din_nxt   = sel.data;
          en_nxt    = 1'b1;
          gid_nxt   = win;
          last_nxt  = win;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (cnt == TXN_LAST) begin
          en_nxt    = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RELEASE;
          if (grant_id) done1_nxt = 1'b1;
          else          done0_nxt = 1'b1;
          // The master's data_out is only meaningful at the end of a read window.
          if (m_rw == RW_READ) begin
            if (grant_id) rdata1_nxt = m_data_out;
            else          rdata0_nxt = m_data_out;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      m_enable  <= 1'b0;
      m_rw      <= RW_WRITE;
      m_addr    <= '0;
      m_data_in <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      grant_id  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      m_enable  <= en_nxt;
      m_rw      <= rw_nxt;
      m_addr    <= addr_nxt;
      m_data_in <= din_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      rdata0    <= rdata0_nxt;
      rdata1    <= rdata1_nxt;
      busy      <= busy_nxt;
      grant_id  <= gid_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: table of request scenarios checked through an expected-grant queue,
// plus hand-written sequences for held requests and reset during a transaction.
module tb_i2c_txn_arbiter;
  import i2c_pkg::*;

  localparam int TXN = 8;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, rw0, req1, rw1;
  logic [6:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       done0, done1;
  logic [7:0] rdata0, rdata1;
  logic       m_enable, m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_data_in, m_data_out;
  logic       busy, grant_id;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.TXN_CYCLES(TXN), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .rw0        (rw0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .done0      (done0),
    .rdata0     (rdata0),
    .req1       (req1),
    .rw1        (rw1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .done1      (done1),
    .rdata1     (rdata1),
    .m_enable   (m_enable),
    .m_rw       (m_rw),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  typedef struct {
    logic       r0, r1, rw0, rw1;
    logic [6:0] a0, a1;
    logic [7:0] w0, w1, d0, d1;
    logic       first;
    logic       chg;
  } vec_t;

  typedef struct {
    logic       id;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  txn_t       exp_q[$];
  txn_t       cur;
  vec_t       vecs[8];
  int         n_chk = 0;
  int         n_pass = 0;
  int         pending, en_len, gap, busy_low;
  logic       prev_en, active;
  logic [7:0] exp_rd0, exp_rd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic txn_t mk(input logic id, input logic rw, input logic [6:0] a,
                              input logic [7:0] w, input logic [7:0] d);
    txn_t t;
    t.id = id; t.rw = rw; t.addr = a; t.wdata = w; t.rdata = d;
    return t;
  endfunction

  // Called once per negedge while a vector runs: matches grants and done pulses to the queue.
  task automatic observe(input vec_t v);
    if (m_enable && !prev_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", exp_q.size(), 1);
      end else begin
        cur = exp_q.pop_front();
        active = 1'b1;
        en_len = 1;
        m_data_out = cur.rdata;
        chk("grant_id", grant_id, cur.id);
        chk("grant_addr", m_addr, cur.addr);
        chk("grant_rw", m_rw, cur.rw);
        chk("grant_wdata", m_data_in, cur.wdata);
        chk("grant_busy", busy, 1);
      end
    end else if (m_enable) begin
      en_len++;
      if (v.chg && en_len == 3 && cur.id == 1'b0) addr0 = 7'h11;
    end
    if (done0 || done1) begin
      chk("done_active", active, 1);
      chk("done_onehot", {done1, done0}, cur.id ? 2'b10 : 2'b01);
      chk("enable_len", en_len, TXN);
      chk("frozen_addr", m_addr, cur.addr);
      if (cur.rw == RW_READ) begin
        if (cur.id) exp_rd1 = cur.rdata;
        else        exp_rd0 = cur.rdata;
      end
      chk("rdata0", rdata0, exp_rd0);
      chk("rdata1", rdata1, exp_rd1);
      active = 1'b0;
      pending--;
      if (cur.id) req1 = 1'b0;
      else        req0 = 1'b0;
    end
    prev_en = m_enable;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    chk("idle", busy, 0);
  endtask

  task automatic wait_done0(input string name);
    for (int c = 0; c < 50 && !done0; c++) @(negedge clk);
    chk(name, done0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    txn_t t0, t1;
    t0 = mk(1'b0, v.rw0, v.a0, v.w0, v.d0);
    t1 = mk(1'b1, v.rw1, v.a1, v.w1, v.d1);
    rw0 = v.rw0; addr0 = v.a0; wdata0 = v.w0;
    rw1 = v.rw1; addr1 = v.a1; wdata1 = v.w1;
    req0 = v.r0; req1 = v.r1;
    pending = 0;
    if (v.r0 && v.r1) begin
      if (v.first) begin exp_q.push_back(t1); exp_q.push_back(t0); end
      else         begin exp_q.push_back(t0); exp_q.push_back(t1); end
      pending = 2;
    end else if (v.r0) begin
      exp_q.push_back(t0); pending = 1;
    end else if (v.r1) begin
      exp_q.push_back(t1); pending = 1;
    end
    prev_en = m_enable;
    active = 1'b0;
    for (int c = 0; c < 200 && pending > 0; c++) begin
      @(negedge clk);
      observe(v);
    end
    chk("vec_complete", pending, 0);
    exp_q.delete();
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
  endtask

  initial begin
    //             r0 r1 rw0 rw1 a0     a1     w0     w1     d0     d1     first chg
    vecs[0] = '{1, 1, 0, 1, 7'h22, 7'h33, 8'h11, 8'h00, 8'hEE, 8'h99, 1'b0, 1'b0};
    vecs[1] = '{1, 0, 0, 0, 7'h50, 7'h00, 8'hA5, 8'h00, 8'hEE, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{0, 1, 0, 1, 7'h00, 7'h68, 8'h00, 8'h00, 8'h00, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{1, 0, 1, 0, 7'h10, 7'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1, 1, 1, 1, 7'h2A, 7'h2B, 8'h00, 8'h00, 8'hC3, 8'h81, 1'b1, 1'b0};
    vecs[5] = '{1, 1, 0, 0, 7'h3A, 7'h3B, 8'hF0, 8'h0F, 8'hEE, 8'hDD, 1'b1, 1'b0};
    vecs[6] = '{1, 0, 0, 0, 7'h50, 7'h00, 8'hA5, 8'h00, 8'hEE, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{1, 0, 0, 0, 7'h11, 7'h00, 8'h5C, 8'h00, 8'hEE, 8'h00, 1'b0, 1'b0};

    rst = 1'b1;
    req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
    m_data_out = '0;
    exp_rd0 = '0; exp_rd1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_enable", m_enable, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_din", m_data_in, 0);
    chk("rst_rw", m_rw, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_rdata", {rdata1, rdata0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Held request: relaunch exactly GAP+1 edges after done, with one idle cycle of busy low.
    req0 = 1'b1; rw0 = 1'b0; addr0 = 7'h40; wdata0 = 8'h77;
    wait_done0("held_done0");
    gap = 0; busy_low = 0;
    for (int k = 1; k <= 6 && gap == 0; k++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (m_enable) gap = k;
    end
    chk("held_gap_edges", gap, GAP + 1);
    chk("held_busy_low", busy_low, 1);
    chk("held_addr", m_addr, 7'h40);
    req0 = 1'b0;
    wait_done0("held_done0_second");
    wait_idle();

    // Reset at cnt=3 of a read: abort without done, then the held req is granted again.
    req0 = 1'b1; rw0 = 1'b1; addr0 = 7'h50; wdata0 = 8'h00; m_data_out = 8'hAB;
    for (int c = 0; c < 20 && !m_enable; c++) @(negedge clk);
    chk("mlr_grant", m_enable, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mlr_enable", m_enable, 0);
    chk("mlr_busy", busy, 0);
    chk("mlr_done", {done1, done0}, 0);
    @(negedge clk);
    chk("mlr_done_hold", {done1, done0}, 0);
    rst = 1'b0;
    exp_rd0 = '0; exp_rd1 = '0;
    @(negedge clk);
    chk("mlr_regrant", m_enable, 1);
    chk("mlr_regrant_addr", m_addr, 7'h50);
    chk("mlr_regrant_gid", grant_id, 0);
    wait_done0("mlr_done0");
    chk("mlr_rdata0", rdata0, 8'hAB);
    req0 = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
